// File: rtl/dcache_dmap_pkg.sv
// Shared constants, FSM encoding and line helpers for the direct-mapped data cache.
// Imported by dcache_dmap and cache_line_store.
package dcache_dmap_pkg;

    localparam int OFFSET_BITS = 4;
    localparam int MEM_ADDR_W  = 28;
    localparam int LINE_BITS   = 128;
    localparam int LINE_BYTES  = LINE_BITS / 8;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LOOKUP      = 3'd1,
        S_WRITEBACK   = 3'd2,
        S_REFILL_REQ  = 3'd3,
        S_REFILL_WAIT = 3'd4
    } state_t;

    function automatic logic [31:0] word_sel(input logic [LINE_BITS-1:0] line,
                                             input logic [1:0]           word);
        return line[{word, 5'b00000} +: 32];
    endfunction

    // Per-byte line mask for a word-sized store placed at the given word offset.
    function automatic logic [LINE_BYTES-1:0] byte_mask(input logic [3:0] we,
                                                        input logic [1:0] word);
        return {12'b0, we} << {word, 2'b00};
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/dirty/tag/data arrays: combinational read by index, one masked synchronous write port.
// Only valid and dirty are reset; tag and data contents are don't-care until written.
module cache_line_store
    import dcache_dmap_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 32 - OFFSET_BITS - IDX_W
) (
    input  logic                  clk,
    input  logic                  i_reset_n,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic                  o_rd_valid,
    output logic                  o_rd_dirty,
    output logic [TAG_W-1:0]      o_rd_tag,
    output logic [LINE_BITS-1:0]  o_rd_data,
    input  logic                  i_wr_en,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [LINE_BYTES-1:0] i_wr_mask,
    input  logic [LINE_BITS-1:0]  i_wr_data,
    input  logic [TAG_W-1:0]      i_wr_tag,
    input  logic                  i_wr_dirty
);

    logic [LINES-1:0]     r_valid;
    logic [LINES-1:0]     r_dirty;
    logic [TAG_W-1:0]     r_tag  [LINES];
    logic [LINE_BITS-1:0] r_data [LINES];

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_dirty = r_dirty[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

    // Every write (store merge or refill) leaves the line valid.
    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
            r_dirty[i_wr_idx] <= i_wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx] <= i_wr_tag;
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (i_wr_mask[b]) begin
                    r_data[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_dmap.sv
// Blocking direct-mapped write-back/write-allocate data cache with a single-beat line memory port.
// Hits complete one cycle after acceptance; misses write back a dirty victim and then refill.
module dcache_dmap
    import dcache_dmap_pkg::*;
#(
    parameter int LINES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic [31:0]           cpu_req_addr,
    input  logic [3:0]            cpu_req_we,
    input  logic [31:0]           cpu_req_data,
    output logic                  cpu_resp_valid,
    output logic [31:0]           cpu_resp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_rw,
    output logic [MEM_ADDR_W-1:0] mem_req_addr,
    output logic [LINE_BITS-1:0]  mem_req_data,
    input  logic                  mem_resp_valid,
    input  logic [LINE_BITS-1:0]  mem_resp_data,
    output logic [2:0]            o_dbg_state
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - OFFSET_BITS - IDX_W;

    state_t r_state;
    state_t w_next;

    logic [31:2] r_addr;
    logic [3:0]  r_we;
    logic [31:0] r_data;

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [1:0]            w_word;
    logic                  w_line_valid;
    logic                  w_line_dirty;
    logic [TAG_W-1:0]      w_line_tag;
    logic [LINE_BITS-1:0]  w_line_data;
    logic                  w_hit;
    logic                  w_accept;
    logic                  w_wr_en;
    logic [LINE_BYTES-1:0] w_wr_mask;
    logic [LINE_BITS-1:0]  w_wr_data;
    logic                  w_wr_dirty;
    logic                  w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^cpu_req_addr[1:0];

    assign w_idx    = r_addr[OFFSET_BITS +: IDX_W];
    assign w_tag    = r_addr[31 -: TAG_W];
    assign w_word   = r_addr[3:2];
    assign w_hit    = w_line_valid && (w_line_tag == w_tag);
    assign w_accept = cpu_req_valid && cpu_req_ready;

    assign o_dbg_state = r_state;

    cache_line_store #(
        .LINES (LINES)
    ) u_store (
        .clk        (clk),
        .i_reset_n  (reset),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_line_valid),
        .o_rd_dirty (w_line_dirty),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (w_idx),
        .i_wr_mask  (w_wr_mask),
        .i_wr_data  (w_wr_data),
        .i_wr_tag   (w_tag),
        .i_wr_dirty (w_wr_dirty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_we    <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr <= cpu_req_addr[31:2];
                r_we   <= cpu_req_we;
                r_data <= cpu_req_data;
            end
        end
    end

    // Memory requests are a pure function of state and the held request/victim line,
    // so they stay stable for as long as the memory side stalls.
    always_comb begin
        w_next         = r_state;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_data  = '0;
        mem_req_valid  = 1'b0;
        mem_req_rw     = 1'b0;
        mem_req_addr   = '0;
        mem_req_data   = '0;
        w_wr_en        = 1'b0;
        w_wr_mask      = '0;
        w_wr_data      = '0;
        w_wr_dirty     = 1'b0;

        case (r_state)
            S_IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    cpu_resp_valid = 1'b1;
                    cpu_req_ready  = 1'b1;
                    if (r_we == 4'b0000) begin
                        cpu_resp_data = word_sel(w_line_data, w_word);
                    end else begin
                        w_wr_en    = 1'b1;
                        w_wr_mask  = byte_mask(r_we, w_word);
                        w_wr_data  = {4{r_data}};
                        w_wr_dirty = 1'b1;
                    end
                    w_next = cpu_req_valid ? S_LOOKUP : S_IDLE;
                end else if (w_line_valid && w_line_dirty) begin
                    w_next = S_WRITEBACK;
                end else begin
                    w_next = S_REFILL_REQ;
                end
            end
            S_WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {w_line_tag, w_idx};
                mem_req_data  = w_line_data;
                if (mem_req_ready) begin
                    w_next = S_REFILL_REQ;
                end
            end
            S_REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = r_addr[31:OFFSET_BITS];
                if (mem_req_ready) begin
                    w_next = S_REFILL_WAIT;
                end
            end
            S_REFILL_WAIT: begin
                if (mem_resp_valid) begin
                    w_wr_en   = 1'b1;
                    w_wr_mask = '1;
                    w_wr_data = mem_resp_data;
                    w_next    = S_LOOKUP;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // While reset is held the block is silent and makes no array writes.
        if (!reset) begin
            cpu_req_ready  = 1'b0;
            cpu_resp_valid = 1'b0;
            cpu_resp_data  = '0;
            mem_req_valid  = 1'b0;
            mem_req_rw     = 1'b0;
            mem_req_addr   = '0;
            mem_req_data   = '0;
            w_wr_en        = 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache_dmap.sv
// Bench for dcache_dmap: directed vectors plus an aliasing mixed load/store run,
// an expected-response queue popped by a monitor, and a line-memory responder.
module tb_dcache_dmap;

    logic         clk;
    logic         reset;
    logic         cpu_req_valid;
    logic         cpu_req_ready;
    logic [31:0]  cpu_req_addr;
    logic [3:0]   cpu_req_we;
    logic [31:0]  cpu_req_data;
    logic         cpu_resp_valid;
    logic [31:0]  cpu_resp_data;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic [2:0]   dbg_state;

    dcache_dmap #(.LINES(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_we     (cpu_req_we),
        .cpu_req_data   (cpu_req_data),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_data  (cpu_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .o_dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;
    int resp_cnt = 0;

    logic [31:0]  exp_q[$];
    logic         log_rw[$];
    logic [27:0]  log_addr[$];
    logic [127:0] log_data[$];

    logic [127:0] mem_model [logic [27:0]];
    logic [31:0]  ref_mem   [logic [29:0]];

    bit rand_ready    = 0;
    bit late_mode     = 0;
    bit spurious_req  = 0;
    int hold_cycles   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] base_line(input logic [27:0] la);
        if (la == 28'h0000100) return 128'hDDDDCCCC_BBBBAAAA_11112222_33334444;
        return {la, 4'h3, la, 4'h2, la, 4'h1, la, 4'h0};
    endfunction

    function automatic logic [127:0] mem_line(input logic [27:0] la);
        if (mem_model.exists(la)) return mem_model[la];
        return base_line(la);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [127:0] l;
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        l = base_line(a[31:4]);
        return l[{a[3:2], 5'b0} +: 32];
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        logic [31:0] w;
        w = ref_read(a);
        for (int b = 0; b < 4; b++) if (we[b]) w[b*8 +: 8] = d[b*8 +: 8];
        ref_mem[a[31:2]] = w;
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d,
                         input logic [31:0] exp, input bit push);
        int guard;
        guard = 0;
        cpu_req_valid = 1'b1;
        cpu_req_addr  = a;
        cpu_req_we    = we;
        cpu_req_data  = d;
        while (cpu_req_ready !== 1'b1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            n_checks++;
            n_err++;
            $display("FAIL req_accept_timeout addr=%h", a);
        end else begin
            if (push) exp_q.push_back(exp);
            if (push && we != 4'b0000) ref_write(a, we, d);
        end
        @(negedge clk);
        cpu_req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        while (!(dbg_state == 3'd0 && exp_q.size() == 0 && mem_req_valid == 1'b0) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_idle_timeout state=%0d pending=%0d", name, dbg_state, exp_q.size());
        end
    endtask

    task automatic clear_log();
        log_rw.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    // ---------------- memory responder ----------------
    logic         rsp_rw;
    logic [27:0]  rsp_addr;
    logic [127:0] rsp_data;
    int           rsp_n;

    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (spurious_req) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = {4{32'hDEAD_BEEF}};
                @(negedge clk);
                mem_resp_valid = 1'b0;
                spurious_req   = 0;
            end else if (mem_req_valid === 1'b1 && reset === 1'b1) begin
                rsp_rw   = mem_req_rw;
                rsp_addr = mem_req_addr;
                rsp_data = mem_req_data;
                rsp_n    = rand_ready ? $urandom_range(0, 3) : hold_cycles;
                for (int i = 0; i < rsp_n; i++) begin
                    @(negedge clk);
                    if (reset === 1'b1)
                        check("mem_req_stable", {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data},
                              {1'b1, rsp_rw, rsp_addr, rsp_data});
                end
                mem_req_ready = 1'b1;
                log_rw.push_back(rsp_rw);
                log_addr.push_back(rsp_addr);
                log_data.push_back(rsp_data);
                @(negedge clk);
                mem_req_ready = 1'b0;
                if (rsp_rw) begin
                    mem_model[rsp_addr] = rsp_data;
                end else begin
                    rsp_n = late_mode ? 6 : (rand_ready ? $urandom_range(0, 7) : 0);
                    repeat (rsp_n) @(negedge clk);
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_line(rsp_addr);
                    @(negedge clk);
                    mem_resp_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [31:0] mon_exp;
    always @(negedge clk) begin
        if (reset === 1'b1 && cpu_resp_valid === 1'b1) begin
            resp_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_resp: got data %h with nothing expected", cpu_resp_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("resp_data", cpu_resp_data, mon_exp);
            end
        end
    end

    // ---------------- main sequence ----------------
    int t0;
    int r0;
    int guard;
    logic [31:0] ra;
    logic [3:0]  rwe;
    logic [31:0] rd;
    logic [31:0] tags [3];

    initial begin
        reset         = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_we    = '0;
        cpu_req_data  = '0;
        tags[0] = 32'h0000_1000;
        tags[1] = 32'h0000_1400;
        tags[2] = 32'h0000_1800;

        repeat (3) @(negedge clk);
        check("rst_ready",     cpu_req_ready,  1'b0);
        check("rst_resp",      cpu_resp_valid, 1'b0);
        check("rst_memvalid",  mem_req_valid,  1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_state", dbg_state,     3'd0);
        check("post_rst_ready", cpu_req_ready, 1'b1);

        // Cold load: single refill of line 0x100, no write-back.
        clear_log();
        r0 = resp_cnt;
        issue(32'h0000_1004, 4'b0000, 32'h0, 32'h1111_2222, 1);
        wait_idle("cold");
        check("cold_resp_count", resp_cnt - r0, 1);
        check("cold_mem_reqs",   log_rw.size(), 1);
        if (log_rw.size() >= 1) begin
            check("cold_mem_rw",   log_rw[0],   1'b0);
            check("cold_mem_addr", log_addr[0], 28'h0000100);
        end

        // Hit latency: response visible in the cycle right after acceptance, no memory traffic.
        issue(32'h0000_1008, 4'b0000, 32'h0, 32'hBBBB_AAAA, 1);
        check("hit_resp_next_cycle", cpu_resp_valid, 1'b1);
        check("hit_no_mem",          mem_req_valid,  1'b0);
        wait_idle("hit");

        // Back-to-back hits: one per cycle.
        t0 = cyc;
        issue(32'h0000_1000, 4'b0000, 32'h0, 32'h3333_4444, 1);
        check("b2b_resp0", cpu_resp_valid, 1'b1);
        issue(32'h0000_1004, 4'b0000, 32'h0, 32'h1111_2222, 1);
        check("b2b_resp1", cpu_resp_valid, 1'b1);
        issue(32'h0000_1008, 4'b0000, 32'h0, 32'hBBBB_AAAA, 1);
        check("b2b_resp2", cpu_resp_valid, 1'b1);
        issue(32'h0000_100C, 4'b0000, 32'h0, 32'hDDDD_CCCC, 1);
        check("b2b_resp3", cpu_resp_valid, 1'b1);
        check("b2b_cycles", cyc - t0, 4);
        wait_idle("b2b");

        // Byte store then back-to-back load of the same word.
        issue(32'h0000_1004, 4'b0010, 32'h0000_AB00, 32'h0, 1);
        issue(32'h0000_1004, 4'b0000, 32'h0,         32'h1111_AB22, 1);
        wait_idle("store_load");

        // Conflict eviction of the dirty line with a stalled memory side.
        clear_log();
        hold_cycles = 5;
        issue(32'h0000_1404, 4'b0000, 32'h0, 32'h0000_1401, 1);
        wait_idle("evict");
        hold_cycles = 0;
        check("evict_mem_reqs", log_rw.size(), 2);
        if (log_rw.size() >= 2) begin
            check("evict_wb_rw",     log_rw[0],   1'b1);
            check("evict_wb_addr",   log_addr[0], 28'h0000100);
            check("evict_wb_data",   log_data[0], 128'hDDDDCCCC_BBBBAAAA_1111AB22_33334444);
            check("evict_refill_rw", log_rw[1],   1'b0);
            check("evict_refill_addr", log_addr[1], 28'h0000140);
        end

        // Spurious refill data while idle is ignored.
        r0 = resp_cnt;
        spurious_req = 1;
        repeat (4) @(negedge clk);
        check("spurious_state", dbg_state, 3'd0);
        check("spurious_resp",  resp_cnt - r0, 0);

        // Reset while waiting for refill data; the late response is ignored.
        late_mode = 1;
        issue(32'h0000_2004, 4'b0000, 32'h0, 32'h0, 0);
        guard = 0;
        while (dbg_state != 3'd4 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("reach_refill_wait", dbg_state, 3'd4);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midmiss_rst_ready", cpu_req_ready, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("midmiss_post_ready", cpu_req_ready, 1'b1);
        check("midmiss_post_state", dbg_state, 3'd0);
        repeat (8) @(negedge clk);
        check("late_resp_state", dbg_state, 3'd0);
        late_mode = 0;

        // Previously cached line misses again after reset (clean, so no write-back).
        clear_log();
        issue(32'h0000_1004, 4'b0000, 32'h0, 32'h1111_AB22, 1);
        wait_idle("recache");
        check("recache_mem_reqs", log_rw.size(), 1);
        if (log_rw.size() >= 1) check("recache_addr", log_addr[0], 28'h0000100);

        // Mixed loads/stores over three aliasing tags with random memory timing.
        rand_ready = 1;
        for (int i = 0; i < 150; i++) begin
            ra  = tags[$urandom_range(0, 2)] + 32'($urandom_range(0, 3) * 16) + 32'($urandom_range(0, 3) * 4);
            rd  = $urandom;
            rwe = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            if (rwe == 4'b0000) issue(ra, 4'b0000, 32'h0, ref_read(ra), 1);
            else                issue(ra, rwe, rd, 32'h0, 1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        wait_idle("random");
        rand_ready = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dcache_dmap.md
Name: dcache_dmap

Overview:
- Blocking, direct-mapped, write-back, write-allocate data cache.
- Sits directly downstream of the CPU datapath's dcache port: it consumes the load/store address, store data and byte enables, and returns load data.
- On a miss it writes back the dirty victim line and refills from main memory over a single-beat 128-bit line interface.
- cpu_req_ready low is the datapath's stall source.

Parameters:
- LINES, 64, number of cache lines; power of two, 4..1024.
- LINE_BITS, 128, line size in bits (4 words); fixed, not overridable in this revision.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  reset; synchronous, active-low (reset==0 resets the block on the next rising edge).
- cpu_req_valid  in  1  CPU request present.
- cpu_req_ready  out  1  cache can accept a request this cycle.
- cpu_req_addr  in  32  byte address; bits [1:0] ignored.
- cpu_req_we  in  4  byte write enables; 4'b0000 = load.
- cpu_req_data  in  32  store data, byte lanes aligned to cpu_req_we.
- cpu_resp_valid  out  1  one-cycle pulse: load data valid / store complete.
- cpu_resp_data  out  32  load data; 0 on store responses.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_rw  out  1  1 = write line, 0 = read line.
- mem_req_addr  out  28  line address (byte address >> 4).
- mem_req_data  out  128  write-back line data.
- mem_resp_valid  in  1  refill data valid.
- mem_resp_data  in  128  refill line.

Behaviour:
- Address split: word offset [3:2]; index [3+log2(LINES):4]; tag = remaining upper bits (22 bits at LINES=64).
- Per line: valid, dirty, tag, 128-bit data. Reset clears every valid and dirty bit; data and tag contents are don't-care.
- Reset values: state=IDLE, cpu_req_ready=0 while reset is asserted, all other outputs 0.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT.
- IDLE:
  - cpu_req_ready=1.
  - On cpu_req_valid&&ready, latch addr/we/data and go to LOOKUP.
- LOOKUP, hit (valid && tag match):
  - Load: cpu_resp_valid=1, cpu_resp_data = selected word in the same cycle.
  - Store: merge the enabled bytes into the line at the end of the cycle, set dirty, cpu_resp_valid=1.
  - cpu_req_ready=1, so a new request may be latched and LOOKUP is re-entered. Sustained hit throughput is 1 per cycle; hit latency is 1 cycle after acceptance.
  - Back-to-back store then load to the same word returns the stored value, because the array write occurs before the next LOOKUP.
- LOOKUP, miss: cpu_req_ready=0; go to WRITEBACK if the victim is valid&&dirty, else to REFILL_REQ.
- WRITEBACK:
  - Drive mem_req_valid=1, rw=1, addr={victim tag, index}, data = victim line.
  - On mem_req_ready, go to REFILL_REQ.
- REFILL_REQ:
  - Drive mem_req_valid=1, rw=0, addr = request line address.
  - On mem_req_ready, go to REFILL_WAIT.
- Memory handshake rule: all mem_req_* outputs stay stable while valid&&!ready.
- REFILL_WAIT:
  - On mem_resp_valid, write the line with valid=1, dirty=0, new tag, then return to LOOKUP. LOOKUP now hits and completes the load or store.
- mem_resp_valid in any state other than REFILL_WAIT is ignored.
- mem_req_ready while mem_req_valid=0 has no effect.
- cpu_resp_valid is exactly one cycle per accepted request; requests are never reordered or dropped.
- Reset mid-miss: the FSM returns to IDLE and any outstanding memory transaction is abandoned; a late mem_resp_valid is ignored. All lines are invalid after reset.
- Store-miss: allocate (refill), then merge in LOOKUP; the line ends dirty.
- Index wrap: addresses differing only in tag map to the same line, which is a conflict eviction.

Decomposition:
- Shared package/header (alongside const.vh): OFFSET_BITS=4, state encodings (IDLE..REFILL_WAIT), MEM_ADDR_W=28.
- Natural sub-module: cache_line_store.
  - Holds valid, dirty, tag and data arrays.
  - Combinational read by index.
  - One synchronous write port with a per-byte mask (full-line write on refill), plus dirty/valid set/clear.
- The FSM and request latch live in dcache_dmap.

Test Plan:
- Cold load at 0x0000_1004 after reset:
  - mem read request, addr=0x0000100, no write-back.
  - Respond with line 0xDDDD_CCCC_BBBB_AAAA_..., where word 1 = 0x1111_2222.
  - Required: cpu_resp_data=0x1111_2222, exactly one cpu_resp_valid pulse.
- Hit timing: a second load to 0x0000_1008 accepted at cycle N gives cpu_resp_valid at N+1 with no mem_req_valid. Back-to-back loads give 1 response per cycle.
- Byte store then load:
  - Store we=4'b0010, data=0x0000_AB00 to 0x0000_1004 (hit).
  - Load the same address: returns 0x1111_AB22; the line is dirty.
- Dirty conflict eviction:
  - Load 0x0000_1404 (same index, LINES=64).
  - Required: WRITEBACK with addr=0x0000100 and the merged line, then a refill read at addr=0x0000140, in that order.
  - Holding mem_req_ready=0 for 5 cycles keeps the request stable.
- Spurious and late responses:
  - mem_resp_valid pulsed in IDLE: no state change.
  - reset=0 asserted during REFILL_WAIT, then released: ready=1, state IDLE.
  - A previously cached address misses again.
- Random mixed loads and stores (byte enables, 3 aliasing tags) against a flat reference memory model with random mem_req_ready and response latency 0-7 cycles: all load data must match.
